// File: rtl/core_id_issue_ctrl.sv
// core_id_issue_ctrl
// Issue controller between decode and execute. It checks decoded operands
// against a 32-entry write-pending scoreboard and stalls on RAW/WAW hazards.
// Hazard-free instructions go into a single registered issue slot that
// execute drains through a valid/ready handshake.
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   i_id_valid/o_id_ready decode handshake (o_id_ready is combinational)
//   i_rs*/i_rd*           decoded operand enables and indices
//   o_ex_valid/i_ex_ready issue slot handshake toward execute
//   o_ex_rd_wen/idx       destination of the slot instruction
//   i_wb_valid/rd_idx     retiring write, clears its pending bit
//   i_flush               kill decode and the unaccepted slot
//   o_scoreboard          pending-write bit per register
//   o_stall_cnt           saturating count of hazard-stall cycles
module core_id_issue_ctrl #(
  parameter int unsigned RFIDX_W     = 5,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_id_valid,
  output logic                   o_id_ready,
  input  logic                   i_rs1_ren,
  input  logic                   i_rs2_ren,
  input  logic                   i_rd_wen,
  input  logic [RFIDX_W-1:0]     i_rs1_idx,
  input  logic [RFIDX_W-1:0]     i_rs2_idx,
  input  logic [RFIDX_W-1:0]     i_rd_idx,
  output logic                   o_ex_valid,
  input  logic                   i_ex_ready,
  output logic                   o_ex_rd_wen,
  output logic [RFIDX_W-1:0]     o_ex_rd_idx,
  input  logic                   i_wb_valid,
  input  logic [RFIDX_W-1:0]     i_wb_rd_idx,
  input  logic                   i_flush,
  output logic [31:0]            o_scoreboard,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned NREG = 32;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e            state_q, state_d;
  logic                   ex_rd_wen_q, ex_rd_wen_d;
  logic [RFIDX_W-1:0]     ex_rd_idx_q, ex_rd_idx_d;
  logic [NREG-1:0]        sb_q, sb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic            ex_valid;
  logic [NREG-1:0] wb_mask, fk_mask, set_mask, eff;
  logic            rs1_haz, rs2_haz, rd_haz, hazard, slot_free, issue;

  assign ex_valid = (state_q == S_FULL);

  // Same-cycle writeback resolves the hazard it retires.
  always_comb begin
    wb_mask = '0;
    if (i_wb_valid) wb_mask = NREG'(1) << i_wb_rd_idx;
    eff = sb_q & ~wb_mask;
  end

  // Hazard detection and issue decision.
  always_comb begin
    rs1_haz   = i_rs1_ren & (i_rs1_idx != '0) & eff[i_rs1_idx];
    rs2_haz   = i_rs2_ren & (i_rs2_idx != '0) & eff[i_rs2_idx];
    rd_haz    = i_rd_wen  & (i_rd_idx  != '0) & eff[i_rd_idx];
    hazard    = rs1_haz | rs2_haz | rd_haz;
    slot_free = ~ex_valid | i_ex_ready;
    issue     = i_id_valid & ~hazard & slot_free & ~i_flush;
  end

  assign o_id_ready = issue;

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Slot next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (i_flush)                          state_d = S_EMPTY;
    else if (issue)                       state_d = S_FULL;
    else if (ex_valid && i_ex_ready)      state_d = S_EMPTY;
  end

  // Slot outputs.
  always_comb begin
    o_ex_valid  = ex_valid;
    o_ex_rd_wen = ex_rd_wen_q;
    o_ex_rd_idx = ex_rd_idx_q;
  end

  // Slot payload, scoreboard and stall counter next values.
  always_comb begin
    ex_rd_wen_d = ex_rd_wen_q;
    ex_rd_idx_d = ex_rd_idx_q;
    if (issue) begin
      ex_rd_wen_d = i_rd_wen;
      ex_rd_idx_d = i_rd_idx;
    end

    // A killed slot never reaches execute, so no writeback will clear it.
    fk_mask = '0;
    if (i_flush && ex_valid && !i_ex_ready && ex_rd_wen_q)
      fk_mask = NREG'(1) << ex_rd_idx_q;

    set_mask = '0;
    if (issue && i_rd_wen && (i_rd_idx != '0))
      set_mask = NREG'(1) << i_rd_idx;

    // Set applied last so it wins over a same-cycle clear.
    sb_d    = (sb_q & ~wb_mask & ~fk_mask) | set_mask;
    sb_d[0] = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (i_id_valid && hazard && !i_flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_wen_q <= 1'b0;
      ex_rd_idx_q <= '0;
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_wen_q <= ex_rd_wen_d;
      ex_rd_idx_q <= ex_rd_idx_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_scoreboard = sb_q;
  assign o_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_core_id_issue_ctrl.sv
// Directed bench for core_id_issue_ctrl: every expected issue pushes the
// destination into a queue, which is popped and compared against the slot
// one cycle later. Scoreboard and counter values are bench constants.
module tb_core_id_issue_ctrl;

  logic        clk, rst_n;
  logic        i_id_valid, o_id_ready;
  logic        i_rs1_ren, i_rs2_ren, i_rd_wen;
  logic [4:0]  i_rs1_idx, i_rs2_idx, i_rd_idx;
  logic        o_ex_valid, i_ex_ready, o_ex_rd_wen;
  logic [4:0]  o_ex_rd_idx;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd_idx;
  logic        i_flush;
  logic [31:0] o_scoreboard;
  logic [31:0] o_stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  core_id_issue_ctrl #(.RFIDX_W(5), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_rs1_ren(i_rs1_ren), .i_rs2_ren(i_rs2_ren), .i_rd_wen(i_rd_wen),
    .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_ex_rd_wen(o_ex_rd_wen), .o_ex_rd_idx(o_ex_rd_idx),
    .i_wb_valid(i_wb_valid), .i_wb_rd_idx(i_wb_rd_idx),
    .i_flush(i_flush),
    .o_scoreboard(o_scoreboard), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic inst(input logic v, input logic r1e, input logic [4:0] r1,
                      input logic r2e, input logic [4:0] r2,
                      input logic rde, input logic [4:0] rd);
    i_id_valid = v;
    i_rs1_ren  = r1e; i_rs1_idx = r1;
    i_rs2_ren  = r2e; i_rs2_idx = r2;
    i_rd_wen   = rde; i_rd_idx  = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] idx);
    i_wb_valid  = v;
    i_wb_rd_idx = idx;
  endtask

  // Check o_id_ready before the edge; on issue, compare the slot after it.
  task automatic step(input string tag, input logic exp_ready);
    logic       pushed;
    logic [4:0] e;
    pushed = 1'b0;
    #1;
    check({tag, "_ready"}, 32'(o_id_ready), 32'(exp_ready));
    if (exp_ready) begin
      exp_q.push_back(i_rd_idx);
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pushed) begin
      e = exp_q.pop_front();
      check({tag, "_slot_valid"}, 32'(o_ex_valid), 32'd1);
      check({tag, "_slot_rd"}, 32'(o_ex_rd_idx), 32'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_ex_ready = 1'b0; i_flush = 1'b0;
    inst(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    #3;
    check("rst_ex_valid", 32'(o_ex_valid), 0);
    check("rst_rd_wen", 32'(o_ex_rd_wen), 0);
    check("rst_rd_idx", 32'(o_ex_rd_idx), 0);
    check("rst_sb", o_scoreboard, 0);
    check("rst_stall", o_stall_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Independent stream
    i_ex_ready = 1'b1;
    inst(1, 1, 0, 0, 0, 1, 1); step("ind1", 1);
    inst(1, 1, 0, 0, 0, 1, 2); step("ind2", 1);
    inst(1, 1, 0, 0, 0, 1, 3); step("ind3", 1);
    check("ind_sb", o_scoreboard, 32'h0000_000E);
    inst(0, 0, 0, 0, 0, 0, 0); step("ind_idle", 0);
    check("ind_drained", 32'(o_ex_valid), 0);
    wb(1, 1); step("ind_wb1", 0);
    wb(1, 2); step("ind_wb2", 0);
    wb(1, 3); step("ind_wb3", 0);
    wb(0, 0);
    check("ind_sb_clr", o_scoreboard, 0);

    // RAW stall
    inst(1, 0, 0, 0, 0, 1, 5); step("raw_prod", 1);
    check("raw_sb", o_scoreboard, 32'h0000_0020);
    inst(1, 1, 5, 0, 0, 1, 5);
    for (int i = 0; i < 4; i++) step("raw_stall", 0);
    check("raw_cnt", o_stall_cnt, 32'd4);
    wb(1, 5); step("raw_wb", 1);
    wb(0, 0);
    check("raw_sb_set_wins", o_scoreboard, 32'h0000_0020);
    check("raw_cnt_hold", o_stall_cnt, 32'd4);
    inst(0, 0, 0, 0, 0, 0, 0);
    wb(1, 5); step("raw_clr", 0);
    wb(0, 0);
    check("raw_sb_clr", o_scoreboard, 0);

    // x0 handling
    inst(1, 0, 0, 0, 0, 1, 0); step("x0_wr", 1);
    inst(1, 1, 0, 1, 0, 1, 0); step("x0_rd", 1);
    check("x0_sb", o_scoreboard, 0);
    check("x0_cnt", o_stall_cnt, 32'd4);

    // Backpressure
    inst(1, 0, 0, 0, 0, 1, 7); step("bp_prod", 1);
    i_ex_ready = 1'b0;
    inst(1, 1, 1, 0, 0, 1, 8);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 0);
      check("bp_hold_rd", 32'(o_ex_rd_idx), 32'd7);
      check("bp_hold_valid", 32'(o_ex_valid), 1);
    end
    i_ex_ready = 1'b1;
    step("bp_release", 1);
    check("bp_sb", o_scoreboard, 32'h0000_0180);
    check("bp_cnt", o_stall_cnt, 32'd4);
    inst(0, 0, 0, 0, 0, 0, 0);
    wb(1, 7); step("bp_wb7", 0);
    wb(1, 8); step("bp_wb8", 0);
    wb(0, 0);
    check("bp_sb_clr", o_scoreboard, 0);

    // Flush kill of an unaccepted slot
    inst(1, 0, 0, 0, 0, 1, 9); step("fk_prod", 1);
    i_ex_ready = 1'b0; i_flush = 1'b1;
    inst(1, 0, 0, 0, 0, 1, 10); step("fk_flush", 0);
    i_flush = 1'b0;
    check("fk_valid", 32'(o_ex_valid), 0);
    check("fk_sb", o_scoreboard, 0);

    // Flush with the slot accepted in the same cycle
    i_ex_ready = 1'b1;
    inst(1, 0, 0, 0, 0, 1, 9); step("fa_prod", 1);
    i_flush = 1'b1;
    inst(1, 0, 0, 0, 0, 1, 10); step("fa_flush", 0);
    i_flush = 1'b0;
    check("fa_valid", 32'(o_ex_valid), 0);
    check("fa_sb", o_scoreboard, 32'h0000_0200);
    inst(0, 0, 0, 0, 0, 0, 0); step("fa_idle", 0);
    check("fa_sb_hold", o_scoreboard, 32'h0000_0200);
    wb(1, 9); step("fa_wb", 0);
    wb(0, 0);
    check("fa_sb_clr", o_scoreboard, 0);

    // Same-cycle set/clear
    inst(1, 0, 0, 0, 0, 1, 4); step("sc_prod", 1);
    wb(1, 4);
    inst(1, 0, 0, 0, 0, 1, 4); step("sc_waw", 1);
    check("sc_sb", o_scoreboard, 32'h0000_0010);
    i_ex_ready = 1'b0;
    inst(0, 0, 0, 0, 0, 0, 0);
    wb(1, 6); step("sc_wb_clear_bit", 0);
    wb(1, 0); step("sc_wb_x0", 0);
    wb(0, 0);
    check("sc_sb_noeffect", o_scoreboard, 32'h0000_0010);
    check("sc_slot_full", 32'(o_ex_valid), 1);

    // Async reset mid-operation, away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ex_valid", 32'(o_ex_valid), 0);
    check("ar_rd_wen", 32'(o_ex_rd_wen), 0);
    check("ar_rd_idx", 32'(o_ex_rd_idx), 0);
    check("ar_sb", o_scoreboard, 0);
    check("ar_stall", o_stall_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ar_post_sb", o_scoreboard, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/core_id_issue_ctrl.md
# core_id_issue_ctrl

Issue controller between the decode stage and the execute stage of the student core. It accepts one decoded instruction per cycle and checks its register operands against a 32-entry write-pending scoreboard. It stalls on RAW/WAW hazards and launches hazard-free instructions into a registered single-entry issue slot using a valid/ready handshake toward execute. Writebacks clear scoreboard entries; a pipeline flush drops the held slot without leaking scoreboard state.

## Interface
- RFIDX_W, 5, register index width (matches core register-file index width)
- STALL_CNT_W, 32, width of the hazard-stall performance counter
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_id_valid  in  1  decode holds a valid instruction
- o_id_ready  out  1  instruction is issued this cycle (combinational)
- i_rs1_ren, i_rs2_ren, i_rd_wen  in  1 each  operand read / destination write enables from decode
- i_rs1_idx, i_rs2_idx, i_rd_idx  in  RFIDX_W each  register indices from decode
- o_ex_valid  out  1  issue slot full
- i_ex_ready  in  1  execute accepts the slot this cycle
- o_ex_rd_wen  out  1  slot instruction writes rd
- o_ex_rd_idx  out  RFIDX_W  slot destination index
- i_wb_valid  in  1  a write (or cancelled write) to i_wb_rd_idx retires this cycle
- i_wb_rd_idx  in  RFIDX_W  retiring destination index
- i_flush  in  1  kill the instruction in decode and the unaccepted slot
- o_scoreboard  out  32  pending-write bit per register; bit 0 is always 0
- o_stall_cnt  out  STALL_CNT_W  cycles lost to operand hazards, saturating

## Operation
- Scoreboard sb[31:0]: bit set means a write to that register is outstanding. x0 is never set.
- Effective scoreboard eff = sb with bit i_wb_rd_idx cleared when i_wb_valid, so a same-cycle writeback resolves the hazard.
- hazard = (rs1_ren & rs1≠0 & eff[rs1]) | (rs2_ren & rs2≠0 & eff[rs2]) | (rd_wen & rd≠0 & eff[rd]).
- slot_free = ~o_ex_valid | i_ex_ready.
- issue = i_id_valid & ~hazard & slot_free & ~i_flush. o_id_ready = issue.
- Slot register, states EMPTY/FULL:
  - On issue: FULL; load rd_wen and rd_idx.
  - Else, if FULL and i_ex_ready: EMPTY.
  - On i_flush: EMPTY regardless of other inputs.
- Scoreboard update, in priority order per bit:
  1. Clear on i_wb_valid for i_wb_rd_idx.
  2. Clear on flush-kill: i_flush & o_ex_valid & ~i_ex_ready & o_ex_rd_wen clears bit o_ex_rd_idx.
  3. Set on issue & i_rd_wen & rd≠0 for i_rd_idx. Set wins over a same-cycle clear of the same index.
- Contract with execute: every slot accepted with o_ex_rd_wen=1 produces exactly one i_wb_valid pulse, including when it is killed downstream. A slot accepted in the same cycle as i_flush counts as accepted.
- Stall counter: increments when i_id_valid & hazard & ~i_flush; holds at all-ones.

## Timing
- Reset (async assert, sync-to-clk release): o_ex_valid=0, o_ex_rd_wen=0, o_ex_rd_idx=0, sb=0, o_stall_cnt=0.
- o_id_ready is combinational from i_id_valid, decode fields, i_wb_*, i_ex_ready, i_flush and state. It has no path from o_id_ready back into itself.
- Issue latency is 1 cycle: o_ex_valid rises the cycle after o_id_ready=1.
- Throughput is one instruction per cycle with i_ex_ready held high and no hazards.
- Back-to-back dependency (producer issued in cycle N, consumer in decode in cycle N+1) stalls until the producer's i_wb_valid. The consumer issues in that same writeback cycle.
- Scoreboard and o_scoreboard update on the clock edge and are visible the next cycle.
- i_wb_valid for index 0 has no effect.
- i_wb_valid for a clear bit has no effect and raises no error.
- Reset mid-operation discards the slot and all pending bits immediately.

## Test plan
- Independent stream: addi x1; addi x2; addi x3 with i_ex_ready=1. Required: o_id_ready=1 on three consecutive cycles, o_ex_rd_idx=1,2,3 one cycle later, and sb bits 1..3 set.
- RAW stall: issue rd=5. Present rs1=5 with no writeback for 4 cycles, then i_wb_valid with idx 5. Required: o_id_ready=0 for 4 cycles, then 1 in the wb cycle; o_stall_cnt=4; sb[5] remains 1 if the consumer also writes x5.
- x0 handling: issue rd=0, then rs1=0 and rs2=0. Required: no stall, and o_scoreboard stays 0.
- Backpressure: slot FULL with rd=7 and i_ex_ready=0 for 3 cycles while the next instruction is independent. Required: o_id_ready=0 and o_ex_rd_idx held at 7. When i_ex_ready=1, the next instruction issues in that same cycle.
- Flush kill: slot FULL with rd=9, i_ex_ready=0, i_flush=1. Required: o_ex_valid=0 and sb[9]=0 next cycle, and the decode instruction is not issued. Repeat with i_ex_ready=1: sb[9] stays 1 until i_wb_valid for 9.
- Same-cycle set/clear: sb[4]=1, i_wb_valid for idx 4, and decode issues a WAW instruction with rd=4. Required: issue occurs and sb[4]=1 the next cycle. Asserting rst_n=0 then clears all outputs asynchronously.
